// File: rtl/slow_set_pkg.sv
// Shared types, default constants and the A-payload field slicer for slow_set_ctl.
package slow_set_pkg;

  typedef enum logic {S_IDLE, S_PEND} state_e;

  localparam int DEF_NCH = 7;
  localparam int DEF_TW  = 4;
  localparam logic [DEF_NCH-1:0] DEF_RST_FLAGS = 7'h37;

  localparam int FIELD_W = 32;

  // Returns the width-bit field of the (zero-extended) payload starting at lsb.
  function automatic logic [FIELD_W-1:0] a_field(input logic [FIELD_W-1:0] a,
                                                 input int lsb,
                                                 input int width);
    return (a >> lsb) & ~({FIELD_W{1'b1}} << width);
  endfunction

endpackage

// File: rtl/slow_set_ctl_if.sv
// Bus-side signals of the slow-mode settings controller, grouped with master/slave views.
interface slow_set_ctl_if
  import slow_set_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int TW  = DEF_TW
) ();

  logic              BACT;
  logic [NCH+TW-1:0] A;
  logic              SetCSWR;
  logic [NCH-1:0]    SlowSel;
  logic [NCH-1:0]    Slow;
  logic [TW-1:0]     SlowTimeout;
  logic              SlowHit;
  logic              TimeoutExp;
  logic              Pending;

  modport master (
    output BACT, A, SetCSWR, SlowSel,
    input  Slow, SlowTimeout, SlowHit, TimeoutExp, Pending
  );

  modport slave (
    input  BACT, A, SetCSWR, SlowSel,
    output Slow, SlowTimeout, SlowHit, TimeoutExp, Pending
  );

endinterface

// File: rtl/slow_timeout_ctr.sv
// Slow-access timeout counter: loads at access start on a slow hit and pulses
// TimeoutExp once, N+1 edges after the access start for a loaded value N.
module slow_timeout_ctr #(
  parameter int TW = 4
) (
  input  logic          CLK,
  input  logic          POR,
  input  logic          BACT,
  input  logic          SlowHit,
  input  logic [TW-1:0] ld_val,
  output logic          TimeoutExp
);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          bact_q, bact_d;
  logic          exp_q, exp_d;

  // Run stays set while the count sits at zero for one edge, which produces the pulse.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    exp_d  = 1'b0;
    bact_d = BACT;
    if (!BACT) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (!bact_q) begin
      if (SlowHit && (ld_val != '0)) begin
        cnt_d = ld_val;
        run_d = 1'b1;
      end
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
        exp_d = 1'b1;
      end else begin
        cnt_d = cnt_q - TW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (POR) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      bact_q <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      bact_q <= bact_d;
      exp_q  <= exp_d;
    end
  end

  assign TimeoutExp = exp_q;

endmodule

// File: rtl/slow_set_ctl.sv
// Slow-mode settings controller. Define SLOW_SET_DEFER_EN to hold captured
// settings in a shadow register until the bus goes idle; otherwise they apply at capture.
module slow_set_ctl
  import slow_set_pkg::*;
#(
  parameter int             NCH       = DEF_NCH,
  parameter int             TW        = DEF_TW,
  parameter logic [NCH-1:0] RST_FLAGS = NCH'(DEF_RST_FLAGS),
  parameter logic [TW-1:0]  RST_TO    = '1
) (
  input logic           CLK,
  input logic           POR,
  slow_set_ctl_if.slave bus
);

  logic [FIELD_W-1:0] a_ext;
  logic [NCH-1:0]     a_flags;
  logic [TW-1:0]      a_to;
  logic               wr, capture;
  logic               wr_q, wr_d;
  logic [NCH-1:0]     slow_q, slow_d;
  logic [TW-1:0]      to_q, to_d;
  logic               slow_hit;
  logic               exp_pulse;

  assign a_ext   = FIELD_W'(bus.A);
  assign a_flags = NCH'(a_field(a_ext, 0, NCH));
  assign a_to    = TW'(a_field(a_ext, NCH, TW));

  assign wr      = bus.BACT && bus.SetCSWR;
  assign capture = wr && !wr_q;

`ifdef SLOW_SET_DEFER_EN
  state_e         state_q, state_d;
  logic [NCH-1:0] sh_flags_q, sh_flags_d;
  logic [TW-1:0]  sh_to_q, sh_to_d;

  // A later capture overwrites the shadow; commit waits for an idle edge.
  always_comb begin
    wr_d       = wr;
    slow_d     = slow_q;
    to_d       = to_q;
    state_d    = state_q;
    sh_flags_d = sh_flags_q;
    sh_to_d    = sh_to_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          sh_flags_d = a_flags;
          sh_to_d    = a_to;
          state_d    = S_PEND;
        end
      end
      S_PEND: begin
        if (capture) begin
          sh_flags_d = a_flags;
          sh_to_d    = a_to;
        end else if (!bus.BACT) begin
          slow_d  = sh_flags_q;
          to_d    = sh_to_q;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (POR) begin
      state_q    <= S_IDLE;
      sh_flags_q <= RST_FLAGS;
      sh_to_q    <= RST_TO;
    end else begin
      state_q    <= state_d;
      sh_flags_q <= sh_flags_d;
      sh_to_q    <= sh_to_d;
    end
  end

  assign bus.Pending = (state_q == S_PEND);
`else
  always_comb begin
    wr_d   = wr;
    slow_d = slow_q;
    to_d   = to_q;
    if (capture) begin
      slow_d = a_flags;
      to_d   = a_to;
    end
  end

  assign bus.Pending = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (POR) begin
      wr_q   <= 1'b0;
      slow_q <= RST_FLAGS;
      to_q   <= RST_TO;
    end else begin
      wr_q   <= wr_d;
      slow_q <= slow_d;
      to_q   <= to_d;
    end
  end

  assign slow_hit = bus.BACT && (|(bus.SlowSel & slow_q));

  slow_timeout_ctr #(.TW(TW)) u_ctr (
    .CLK        (CLK),
    .POR        (POR),
    .BACT       (bus.BACT),
    .SlowHit    (slow_hit),
    .ld_val     (to_q),
    .TimeoutExp (exp_pulse)
  );

  assign bus.Slow        = slow_q;
  assign bus.SlowTimeout = to_q;
  assign bus.SlowHit     = slow_hit;
  assign bus.TimeoutExp  = exp_pulse;

endmodule

// File: tb/tb_slow_set_ctl.sv
// Directed testbench for slow_set_ctl: a per-edge vector table plus hand-written
// timeout, early-end, miss and reset-while-pending sequences.
module tb_slow_set_ctl;

`ifdef SLOW_SET_DEFER_EN
  localparam bit DEFER = 1'b1;
`else
  localparam bit DEFER = 1'b0;
`endif

  logic CLK = 1'b0;
  logic POR;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  slow_set_ctl_if bus ();

  slow_set_ctl dut (
    .CLK (CLK),
    .POR (POR),
    .bus (bus)
  );

  typedef struct {
    logic        por;
    logic        bact;
    logic        wr;
    logic [10:0] a;
    logic [6:0]  sel;
    logic [6:0]  e_slow;
    logic [3:0]  e_to;
    logic        e_hit;
    logic        e_exp;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic por, input logic bact, input logic wr,
                                 input logic [10:0] a, input logic [6:0] sel,
                                 input logic [6:0] e_slow, input logic [3:0] e_to,
                                 input logic e_hit, input logic e_exp, input logic e_pend);
    vec_t v;
    v.por = por; v.bact = bact; v.wr = wr; v.a = a; v.sel = sel;
    v.e_slow = e_slow; v.e_to = e_to; v.e_hit = e_hit; v.e_exp = e_exp; v.e_pend = e_pend;
    vecs.push_back(v);
  endfunction

  // Drive inputs just after an edge, then advance to 1 time unit past the next edge.
  task automatic applyStimulus(input logic por, input logic bact, input logic wr,
                               input logic [10:0] a, input logic [6:0] sel);
    POR         = por;
    bus.BACT    = bact;
    bus.SetCSWR = wr;
    bus.A       = a;
    bus.SlowSel = sel;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkField(input string what, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", what, act, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] e_slow, input logic [3:0] e_to,
                             input logic e_hit, input logic e_exp, input logic e_pend);
    checkField({tag, ".Slow"},        32'(bus.Slow),        32'(e_slow));
    checkField({tag, ".SlowTimeout"}, 32'(bus.SlowTimeout), 32'(e_to));
    checkField({tag, ".SlowHit"},     32'(bus.SlowHit),     32'(e_hit));
    checkField({tag, ".TimeoutExp"},  32'(bus.TimeoutExp),  32'(e_exp));
    checkField({tag, ".Pending"},     32'(bus.Pending),     32'(e_pend));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    POR = 1'b1; bus.BACT = 1'b0; bus.SetCSWR = 1'b0; bus.A = '0; bus.SlowSel = '0;

    // por bact wr a        sel     Slow                  Timeout             hit exp pend
    addVec(1, 0, 0, 11'h000, 7'h00, 7'h37,                4'hF,                0, 0, 0);
    addVec(1, 0, 0, 11'h000, 7'h00, 7'h37,                4'hF,                0, 0, 0);
    addVec(0, 0, 0, 11'h000, 7'h00, 7'h37,                4'hF,                0, 0, 0);
    addVec(0, 1, 1, 11'h2A5, 7'h00, DEFER ? 7'h37 : 7'h25, DEFER ? 4'hF : 4'h5, 0, 0, DEFER);
    addVec(0, 1, 1, 11'h7FF, 7'h00, DEFER ? 7'h37 : 7'h25, DEFER ? 4'hF : 4'h5, 0, 0, DEFER);
    addVec(0, 1, 1, 11'h7FF, 7'h00, DEFER ? 7'h37 : 7'h25, DEFER ? 4'hF : 4'h5, 0, 0, DEFER);
    addVec(0, 0, 0, 11'h000, 7'h00, 7'h25,                4'h5,                0, 0, 0);
    addVec(0, 0, 0, 11'h000, 7'h00, 7'h25,                4'h5,                0, 0, 0);
    addVec(0, 1, 1, 11'h100, 7'h00, DEFER ? 7'h25 : 7'h00, DEFER ? 4'h5 : 4'h2, 0, 0, DEFER);
    addVec(0, 1, 0, 11'h000, 7'h00, DEFER ? 7'h25 : 7'h00, DEFER ? 4'h5 : 4'h2, 0, 0, DEFER);
    addVec(0, 1, 1, 11'h3FF, 7'h00, DEFER ? 7'h25 : 7'h7F, DEFER ? 4'h5 : 4'h7, 0, 0, DEFER);
    addVec(0, 0, 0, 11'h000, 7'h00, 7'h7F,                4'h7,                0, 0, 0);
    addVec(0, 1, 0, 11'h000, 7'h40, 7'h7F,                4'h7,                1, 0, 0);
    addVec(0, 1, 0, 11'h000, 7'h00, 7'h7F,                4'h7,                0, 0, 0);
    addVec(0, 0, 0, 11'h000, 7'h40, 7'h7F,                4'h7,                0, 0, 0);
    addVec(0, 1, 1, 11'h181, 7'h00, DEFER ? 7'h7F : 7'h01, DEFER ? 4'h7 : 4'h3, 0, 0, DEFER);
    addVec(0, 0, 0, 11'h000, 7'h00, 7'h01,                4'h3,                0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].por, vecs[i].bact, vecs[i].wr, vecs[i].a, vecs[i].sel);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_slow, vecs[i].e_to,
                  vecs[i].e_hit, vecs[i].e_exp, vecs[i].e_pend);
    end

    // Timeout 3 on channel 0: single pulse four edges after access start.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 0, 11'h000, 7'h01);
      checkOutput($sformatf("to3_k%0d", k), 7'h01, 4'h3, 1'b1, (k == 4), 1'b0);
    end
    applyStimulus(0, 0, 0, 11'h000, 7'h00);
    checkOutput("to3_end", 7'h01, 4'h3, 1'b0, 1'b0, 1'b0);

    // Timeout 0 disables expiry.
    applyStimulus(0, 1, 1, 11'h001, 7'h00);
    checkOutput("wr_to0", 7'h01, DEFER ? 4'h3 : 4'h0, 1'b0, 1'b0, DEFER);
    applyStimulus(0, 0, 0, 11'h000, 7'h00);
    checkOutput("commit_to0", 7'h01, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 0, 11'h000, 7'h01);
      checkOutput($sformatf("to0_k%0d", k), 7'h01, 4'h0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(0, 0, 0, 11'h000, 7'h00);

    // Timeout 5, access ending after two edges gives no pulse.
    applyStimulus(0, 1, 1, 11'h281, 7'h00);
    checkOutput("wr_to5", 7'h01, DEFER ? 4'h0 : 4'h5, 1'b0, 1'b0, DEFER);
    applyStimulus(0, 0, 0, 11'h000, 7'h00);
    checkOutput("commit_to5", 7'h01, 4'h5, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 0, 11'h000, 7'h01);
      checkOutput($sformatf("early_k%0d", k), 7'h01, 4'h5, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 11'h000, 7'h01);
      checkOutput($sformatf("early_idle%0d", k), 7'h01, 4'h5, 1'b0, 1'b0, 1'b0);
    end

    // A full-length access afterwards still expires at N+1 = 6 edges.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 0, 11'h000, 7'h01);
      checkOutput($sformatf("to5_k%0d", k), 7'h01, 4'h5, 1'b1, (k == 6), 1'b0);
    end
    applyStimulus(0, 0, 0, 11'h000, 7'h00);

    // Access targeting only a disabled channel.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 0, 11'h000, 7'h02);
      checkOutput($sformatf("miss_k%0d", k), 7'h01, 4'h5, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(0, 0, 0, 11'h000, 7'h00);

    // Reset while a capture is pending discards it.
    applyStimulus(0, 1, 1, 11'h000, 7'h00);
    checkOutput("rstpend_cap", DEFER ? 7'h01 : 7'h00, DEFER ? 4'h5 : 4'h0, 1'b0, 1'b0, DEFER);
    applyStimulus(1, 1, 1, 11'h000, 7'h00);
    checkOutput("rstpend_por", 7'h37, 4'hF, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 11'h000, 7'h00);
      checkOutput($sformatf("rstpend_idle%0d", k), 7'h37, 4'hF, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
